uart_rx: RTL

//  Serial receiver on the far end of the UART transmit line. It reassembles

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, DBITS data bits LSB first, SBITS stop bits.
//   state | meaning
//   IDLE  | line idle, waiting for a low level
//   START | counting to mid start bit to confirm it is not a glitch
//   DATA  | sampling data bits at mid bit
//   STOP  | sampling stop bits; a low stop bit is a framing error
//   BREAK | framing error seen, waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int SBITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             rx,
  output logic [DBITS-1:0] dout,
  output logic             rx_done_tick,
  output logic             frame_err,
  output logic             rx_idle
);

  localparam logic [2:0] BIT_LAST  = 3'(DBITS - 1);
  localparam logic       STOP_LAST = 1'(SBITS - 1);

  uart_state_e      state, state_n;
  logic [3:0]       tick_cnt, tick_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             stop_cnt, stop_cnt_n;
  logic [DBITS-1:0] shreg, shreg_n;
  logic [DBITS-1:0] dout_n;
  logic             done_n, ferr_n;
  logic             rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      tick_cnt     <= tick_cnt_n;
      bit_cnt      <= bit_cnt_n;
      stop_cnt     <= stop_cnt_n;
      shreg        <= shreg_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    shreg_n    = shreg;
    dout_n     = dout;
    done_n     = 1'b0;
    ferr_n     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt == MID_TICK) begin
            if (!rx_s) begin
              state_n    = DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt == LAST_TICK) begin
            shreg_n    = {rx_s, shreg[DBITS-1:1]};
            tick_cnt_n = '0;
            if (bit_cnt == BIT_LAST) begin
              state_n    = STOP;
              stop_cnt_n = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_n = '0;
            if (!rx_s) begin
              dout_n  = shreg;
              done_n  = 1'b1;
              ferr_n  = 1'b1;
              state_n = BREAK;
            end else if (stop_cnt == STOP_LAST) begin
              dout_n  = shreg;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              stop_cnt_n = stop_cnt + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_idle = (state == IDLE);

endmodule
